shape_ctrl_initiator: RTL and testbench

Bus-side initiator for the shape processor's control SFR. It accepts {shape, operation} configuration requests over a valid/ready handshake and writes them to the control SFR. It then reads the SFR back and classifies the outcome from the `error` flag and the readback. It sits between the configuration sequencer and the shape processor's `write`/`read` port, driving the same signals the processor receives.

---
 rtl/shape_ctrl_initiator_pkg.sv | 58 +++++
 rtl/shape_ctrl_initiator.sv | 139 +++++++++++++
 tb/tb_shape_ctrl_initiator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shape_ctrl_initiator_pkg.sv
// Shared types for the shape processor control SFR and its bus initiator.
//   shape_t / operation_t : SFR field encodings (unused codes are illegal)
//   ctrl_sfr_reg          : 32-bit control SFR image
//   is_legal_*            : legality rules applied by the target and by the
//                           optional initiator precheck
//   rsp_status_e          : initiator outcome classification
//   init_state_e          : initiator FSM states
package shape_ctrl_initiator_pkg;

    typedef enum logic [2:0] {
        SHAPE_CIRCLE   = 3'd0,
        SHAPE_SQUARE   = 3'd1,
        SHAPE_TRIANGLE = 3'd2,
        SHAPE_HEXAGON  = 3'd3
    } shape_t;

    typedef enum logic [1:0] {
        OP_AREA      = 2'd0,
        OP_PERIMETER = 2'd1,
        OP_SCALE     = 2'd2
    } operation_t;

    typedef struct packed {
        logic [26:0] reserved;
        operation_t  operation;
        shape_t      shape;
    } ctrl_sfr_reg;

    typedef enum logic [1:0] {
        RSP_OK           = 2'd0,
        RSP_REJECTED     = 2'd1,
        RSP_MISMATCH     = 2'd2,
        RSP_LOCAL_REJECT = 2'd3
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOCAL = 3'd4,
        ST_RESP  = 3'd5
    } init_state_e;

    function automatic logic is_legal_shape(input shape_t s);
        return s inside {SHAPE_CIRCLE, SHAPE_SQUARE, SHAPE_TRIANGLE, SHAPE_HEXAGON};
    endfunction

    function automatic logic is_legal_operation(input operation_t o);
        return o inside {OP_AREA, OP_PERIMETER, OP_SCALE};
    endfunction

    // Scaling a triangle is the one field pairing the processor refuses.
    function automatic logic is_legal_combination(input shape_t s, input operation_t o);
        return !(s == SHAPE_TRIANGLE && o == OP_SCALE);
    endfunction

endpackage

// File: rtl/shape_ctrl_initiator.sv
// Bus initiator for the shape processor control SFR.
// Accepts one {shape, operation} request, writes it to the SFR, reads it
// back READ_LATENCY cycles later and reports OK / REJECTED / MISMATCH, or
// LOCAL_REJECT when PRECHECK refuses the request without touching the bus.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready/req_*      request handshake and fields
//   write/write_data               one-cycle SFR write strobe and image
//   read/read_data/error           one-cycle read strobe, readback, reject flag
//   rsp_valid/rsp_ready/rsp_*      response handshake, status and readback
//   busy                           transaction in flight
module shape_ctrl_initiator
    import shape_ctrl_initiator_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter bit PRECHECK     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  shape_t      req_shape,
    input  operation_t  req_operation,
    output logic        write,
    output logic [31:0] write_data,
    output logic        read,
    input  logic [31:0] read_data,
    input  logic        error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_readback,
    output logic        busy
);

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    init_state_e state_q, state_d;
    shape_t      shape_q, shape_d;
    operation_t  op_q, op_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    rsp_status_e status_q, status_d;
    logic [31:0] readback_q, readback_d;

    ctrl_sfr_reg wr_img;
    ctrl_sfr_reg rd_img;
    logic        match;

    always_comb begin
        wr_img           = '0;
        wr_img.shape     = shape_q;
        wr_img.operation = op_q;
        rd_img           = ctrl_sfr_reg'(read_data);
        // Reserved readback bits do not take part in the compare.
        match            = (rd_img.shape == shape_q) && (rd_img.operation == op_q);
    end

    always_comb begin
        state_d    = state_q;
        shape_d    = shape_q;
        op_d       = op_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        readback_d = readback_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    shape_d = req_shape;
                    op_d    = req_operation;
                    if (PRECHECK && !(is_legal_shape(req_shape) &&
                                      is_legal_operation(req_operation) &&
                                      is_legal_combination(req_shape, req_operation)))
                        state_d = ST_LOCAL;
                    else
                        state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ: begin
                // error reports on the write of the previous cycle
                err_d   = error;
                cnt_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    readback_d = read_data;
                    if (match && !err_q)      status_d = RSP_OK;
                    else if (!match && err_q) status_d = RSP_REJECTED;
                    else                      status_d = RSP_MISMATCH;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_LOCAL: begin
                status_d   = RSP_LOCAL_REJECT;
                readback_d = '0;
                state_d    = ST_RESP;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shape_q    <= SHAPE_CIRCLE;
            op_q       <= OP_AREA;
            err_q      <= 1'b0;
            cnt_q      <= 3'd0;
            status_q   <= RSP_OK;
            readback_q <= '0;
        end else begin
            state_q    <= state_d;
            shape_q    <= shape_d;
            op_q       <= op_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            readback_q <= readback_d;
        end
    end

    // All outputs decode from registered state, so they are glitch-free and
    // take their reset values at the first reset edge.
    assign req_ready    = (state_q == ST_IDLE);
    assign write        = (state_q == ST_WRITE);
    assign write_data   = (state_q == ST_WRITE) ? 32'(wr_img) : 32'd0;
    assign read         = (state_q == ST_READ);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_status   = status_q;
    assign rsp_readback = readback_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shape_ctrl_initiator.sv
// Bench for shape_ctrl_initiator. Two instances: u0 (READ_LATENCY=1,
// PRECHECK=1) and u1 (READ_LATENCY=3, PRECHECK=0), each with an SFR target
// stub. A directed table, a reset-mid-operation sequence and random
// requests are checked against a field-level model of the target SFR.
module tb_shape_ctrl_initiator;
    import shape_ctrl_initiator_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req_valid [2];
    logic        req_ready [2];
    shape_t      req_shape [2];
    operation_t  req_operation [2];
    logic        write [2];
    logic [31:0] write_data [2];
    logic        read [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [1:0]  rsp_status [2];
    logic [31:0] rsp_readback [2];
    logic        busy [2];
    logic [31:0] cmask [2];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] msfr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        error = 1'b0;
        logic [31:0] read_data = '1;
        logic [31:0] sfr = '0;
        logic        pend_err = 1'b0;
        int          rd_cnt = 0;

        shape_ctrl_initiator #(
            .READ_LATENCY(g == 0 ? 1 : 3),
            .PRECHECK    (g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_shape    (req_shape[g]),
            .req_operation(req_operation[g]),
            .write        (write[g]),
            .write_data   (write_data[g]),
            .read         (read[g]),
            .read_data    (read_data),
            .error        (error),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_status   (rsp_status[g]),
            .rsp_readback (rsp_readback[g]),
            .busy         (busy[g])
        );

        // Target stub: updates inputs at negedge for the following posedge.
        // Data is valid only at the exact sampling edge; otherwise ~sfr.
        always @(negedge clk) begin
            logic pres;
            logic [2:0] ws;
            logic [1:0] wo;
            pres     = 1'b0;
            error    = pend_err;
            pend_err = 1'b0;
            if (write[g]) begin
                ws = write_data[g][2:0];
                wo = write_data[g][4:3];
                if (ws <= 3'd3 && wo != 2'd3 && !(ws == 3'd2 && wo == 2'd2))
                    sfr = write_data[g];
                else
                    pend_err = 1'b1;
            end
            if (read[g]) begin
                rd_cnt = (g == 0) ? 1 : 3;
            end else if (rd_cnt > 0) begin
                rd_cnt = rd_cnt - 1;
                pres   = (rd_cnt == 0);
            end
            read_data = pres ? (sfr ^ cmask[g]) : ~sfr;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: target SFR as a plain value; outcome from field equality.
    task automatic model(input int i, input logic [2:0] s, input logic [1:0] o,
                         input logic [31:0] mask, output logic [1:0] st,
                         output logic [31:0] rb, output int cyc);
        logic [31:0] img;
        logic legal, match;
        img   = {27'd0, o, s};
        legal = (s < 4) && (o < 3) && !(s == 2 && o == 2);
        if (i == 0 && !legal) begin
            st = 2'd3; rb = 32'd0; cyc = 2;
        end else begin
            if (legal) msfr[i] = img;
            rb    = msfr[i] ^ mask;
            match = (rb[4:0] == img[4:0]);
            if (match && legal)       st = 2'd0;
            else if (!match && !legal) st = 2'd1;
            else                      st = 2'd2;
            cyc = 3 + ((i == 0) ? 1 : 3);
        end
    endtask

    task automatic run_txn(input int i, input logic [2:0] s, input logic [1:0] o,
                           input logic [31:0] mask, input int hold,
                           input logic [1:0] exp_st, input logic [31:0] exp_rb,
                           input int exp_cyc);
        int wcyc, rcyc, vcyc, nwr, nrd;
        logic wd_ok, overlap, stable;
        logic [1:0] st;
        logic [31:0] rb, img;
        bit loc;
        img = {27'd0, o, s};
        loc = (exp_st == 2'd3);
        @(negedge clk);
        chk("req_ready_idle", req_ready[i], 1'b1);
        cmask[i] = mask;
        req_valid[i] = 1'b1;
        req_shape[i] = shape_t'(s);
        req_operation[i] = operation_t'(o);
        @(posedge clk);
        wcyc = -1; rcyc = -1; vcyc = -1; nwr = 0; nrd = 0;
        wd_ok = 1'b1; overlap = 1'b0;
        for (int k = 1; k <= 40 && vcyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[i] = 1'b0;
            if (write[i]) begin
                nwr++; wcyc = k;
                if (write_data[i] !== img) wd_ok = 1'b0;
            end else if (write_data[i] !== 32'd0) wd_ok = 1'b0;
            if (read[i]) begin nrd++; rcyc = k; end
            if (write[i] && read[i]) overlap = 1'b1;
            if (rsp_valid[i]) vcyc = k;
        end
        chk("write_cycle", 64'(wcyc), loc ? 64'(-1) : 64'd1);
        chk("read_cycle", 64'(rcyc), loc ? 64'(-1) : 64'd2);
        chk("strobe_counts", {nwr[31:0], nrd[31:0]}, loc ? 64'd0 : {32'd1, 32'd1});
        chk("write_data", {wd_ok, overlap}, 2'b10);
        chk("rsp_valid_cycle", 64'(vcyc), 64'(exp_cyc));
        st = rsp_status[i];
        rb = rsp_readback[i];
        chk("rsp_status", st, exp_st);
        chk("rsp_readback", rb, exp_rb);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            if (!rsp_valid[i] || rsp_status[i] !== st || rsp_readback[i] !== rb ||
                req_ready[i]) stable = 1'b0;
        end
        if (hold > 0) chk("rsp_stable", stable, 1'b1);
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk("post_handshake", {req_ready[i], rsp_valid[i], busy[i]}, 3'b100);
    endtask

    typedef struct {
        int          inst;
        logic [2:0]  s;
        logic [1:0]  o;
        logic [31:0] mask;
        int          hold;
        logic [1:0]  st;
        logic [31:0] rb;
        int          cyc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [1:0] st;
        logic [31:0] rb;
        int cyc, nv, i, sel;
        logic [2:0] s;
        logic [1:0] o;
        logic [31:0] mask;

        tbl[0] = '{0, 3'd1, 2'd2, 32'h0,        0, 2'd0, 32'h11,       4};
        tbl[1] = '{0, 3'd2, 2'd2, 32'h0,        0, 2'd3, 32'h0,        2};
        tbl[2] = '{1, 3'd5, 2'd0, 32'h0,        5, 2'd1, 32'h0,        6};
        tbl[3] = '{0, 3'd3, 2'd1, 32'h8,        0, 2'd2, 32'h3,        4};
        tbl[4] = '{1, 3'd0, 2'd0, 32'h80000000, 1, 2'd0, 32'h80000000, 6};
        tbl[5] = '{1, 3'd2, 2'd2, 32'h0,        0, 2'd1, 32'h0,        6};
        tbl[6] = '{0, 3'd1, 2'd3, 32'h0,        2, 2'd3, 32'h0,        2};
        tbl[7] = '{0, 3'd0, 2'd1, 32'h0,        1, 2'd0, 32'h8,        4};

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
            req_shape[k] = SHAPE_CIRCLE; req_operation[k] = OP_AREA;
            cmask[k] = '0; msfr[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            chk("reset_outputs", {req_ready[k], write[k], read[k], rsp_valid[k], busy[k],
                                  write_data[k], rsp_readback[k], rsp_status[k]},
                {1'b1, 4'b0, 32'd0, 32'd0, 2'd0});
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int t = 0; t < 8; t++) begin
            model(tbl[t].inst, tbl[t].s, tbl[t].o, tbl[t].mask, st, rb, cyc);
            run_txn(tbl[t].inst, tbl[t].s, tbl[t].o, tbl[t].mask, tbl[t].hold,
                    tbl[t].st, tbl[t].rb, tbl[t].cyc);
        end

        // Reset during READ: write already landed, response must be dropped.
        @(negedge clk);
        cmask[0] = '0;
        req_valid[0] = 1'b1; req_shape[0] = SHAPE_HEXAGON; req_operation[0] = OP_AREA;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("pre_reset_read", read[0], 1'b1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_reset_outputs", {req_ready[0], write[0], read[0], rsp_valid[0], busy[0],
                                    write_data[0], rsp_readback[0], rsp_status[0]},
            {1'b1, 4'b0, 32'd0, 32'd0, 2'd0});
        @(negedge clk);
        rst_n[0] = 1'b1;
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid[0] || busy[0]) nv++;
        end
        chk("no_rsp_after_reset", 64'(nv), 64'd0);
        msfr[0] = 32'h3;
        model(0, 3'd1, 2'd1, 32'h0, st, rb, cyc);
        run_txn(0, 3'd1, 2'd1, 32'h0, 0, 2'd0, 32'h9, 4);

        for (int r = 0; r < 40; r++) begin
            i   = int'($urandom_range(0, 1));
            s   = 3'($urandom_range(0, 7));
            o   = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 4));
            case (sel)
                1:       mask = 32'd1 << $urandom_range(3, 4);
                2:       mask = 32'd1 << $urandom_range(0, 2);
                3:       mask = 32'd1 << $urandom_range(5, 31);
                default: mask = 32'd0;
            endcase
            model(i, s, o, mask, st, rb, cyc);
            run_txn(i, s, o, mask, int'($urandom_range(0, 3)), st, rb, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
